// File: rtl/memctrl_pkg.sv
// Shared encodings for the memory controller: access lengths, controller states
// and the default IO region base.
package memctrl_pkg;

   localparam int unsigned CNT_W = 3;

   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd2;

   // addr[17:16] == 2'b11 selects the IO space.
   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

   typedef enum logic [1:0] {
      MC_IDLE  = 2'd0,
      MC_READ  = 2'd1,
      MC_WRITE = 2'd2
   } mc_state_t;

   // Byte count of an access; the unused encoding is served as a word.
   function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
      case (len)
         LEN_BYTE: return 3'd1;
         LEN_HALF: return 3'd2;
         default:  return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/memctrl.sv
// Arbitrates icache and LSB requests onto the byte-wide RAM/IO port, serialising
// 1/2/4-byte little-endian accesses one at a time.
module memctrl
   import memctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear_in,
   input  logic              io_buffer_full,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_done,
   output logic [31:0]       ic_data,
   input  logic              ls_req,
   input  logic              ls_wr,
   input  logic [1:0]        ls_len,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata
);

   localparam logic [1:0] IO_SEL = IO_BASE[17:16];

   mc_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  n;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wdata;
   logic [31:0]       rbuf;
   logic              owner_ls;

   logic [ADDR_W-1:0] byte_addr_c;
   logic [1:0]        wr_idx_c;
   logic [1:0]        rd_idx_c;
   logic [7:0]        wr_byte_c;
   logic              write_stall_c;
   logic              first_stall_c;

   // cnt is the number of bytes already issued, so it also indexes the next byte.
   assign byte_addr_c   = base + ADDR_W'(cnt);
   assign wr_idx_c      = cnt[1:0];
   assign rd_idx_c      = 2'(cnt - 3'd1);
   assign wr_byte_c     = wdata[{wr_idx_c, 3'b000} +: 8];
   assign write_stall_c = io_buffer_full && (byte_addr_c[17:16] == IO_SEL);
   assign first_stall_c = io_buffer_full && (ls_addr[17:16] == IO_SEL);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= MC_IDLE;
         cnt      <= '0;
         n        <= '0;
         base     <= '0;
         wdata    <= '0;
         rbuf     <= '0;
         owner_ls <= 1'b0;
         mem_a    <= '0;
         mem_dout <= '0;
         mem_wr   <= 1'b0;
         ic_done  <= 1'b0;
         ic_data  <= '0;
         ls_done  <= 1'b0;
         ls_rdata <= '0;
      end else if (rdy_in) begin
         ic_done <= 1'b0;
         ls_done <= 1'b0;
         case (state)
            MC_IDLE: begin
               mem_wr <= 1'b0;
               // LSB wins over icache; a flush blocks acceptance this edge.
               if (!clear_in && (ls_req || ic_req)) begin
                  owner_ls <= ls_req;
                  rbuf     <= '0;
                  wdata    <= ls_wdata;
                  cnt      <= 3'd1;
                  if (ls_req) begin
                     base <= ls_addr;
                     n    <= len_bytes(ls_len);
                  end else begin
                     base <= ic_addr;
                     n    <= 3'd4;
                  end
                  if (ls_req && ls_wr) begin
                     state <= MC_WRITE;
                     if (first_stall_c) begin
                        cnt <= '0;
                     end else begin
                        mem_a    <= ls_addr;
                        mem_dout <= ls_wdata[7:0];
                        mem_wr   <= 1'b1;
                     end
                  end else begin
                     state <= MC_READ;
                     mem_a <= ls_req ? ls_addr : ic_addr;
                  end
               end
            end

            MC_READ: begin
               if (clear_in) begin
                  state <= MC_IDLE;
                  cnt   <= '0;
                  mem_a <= '0;
               end else if (cnt == n + 3'd1) begin
                  state <= MC_IDLE;
                  cnt   <= '0;
                  if (owner_ls) begin
                     ls_rdata <= rbuf;
                     ls_done  <= 1'b1;
                  end else begin
                     ic_data <= rbuf;
                     ic_done <= 1'b1;
                  end
               end else begin
                  // Byte cnt-1 is on mem_din; issue the next address or park at 0.
                  rbuf[{rd_idx_c, 3'b000} +: 8] <= mem_din;
                  mem_a <= (cnt < n) ? byte_addr_c : '0;
                  cnt   <= cnt + 3'd1;
               end
            end

            MC_WRITE: begin
               if (cnt == n) begin
                  state   <= MC_IDLE;
                  cnt     <= '0;
                  mem_wr  <= 1'b0;
                  mem_a   <= '0;
                  ls_done <= 1'b1;
               end else if (write_stall_c) begin
                  mem_wr <= 1'b0;
               end else begin
                  mem_a    <= byte_addr_c;
                  mem_dout <= wr_byte_c;
                  mem_wr   <= 1'b1;
                  cnt      <= cnt + 3'd1;
               end
            end

            default: begin
               state  <= MC_IDLE;
               cnt    <= '0;
               mem_wr <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memctrl.sv
// Self-checking bench for memctrl: directed scenarios plus randomized traffic
// checked against a byte-array memory model.
module tb_memctrl;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        clear_in;
   logic        io_buffer_full;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_done;
   logic [31:0] ic_data;
   logic        ls_req;
   logic        ls_wr;
   logic [1:0]  ls_len;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;

   memctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .ic_req(ic_req), .ic_addr(ic_addr),
      .ic_done(ic_done), .ic_data(ic_data), .ls_req(ls_req), .ls_wr(ls_wr),
      .ls_len(ls_len), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done),
      .ls_rdata(ls_rdata)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Environment RAM (64 KiB, indexed by low address bits) plus IO write log.
   logic [7:0]  ram   [0:65535];
   logic [7:0]  model [0:65535];
   logic [39:0] wr_log [$];
   logic [39:0] io_log [$];
   bit          filled;
   logic        pre_en;
   logic [15:0] pre_addr;
   logic [7:0]  pre_data;

   logic [31:0] a_trace [$];
   logic        w_trace [$];
   int          checks;
   int          errors;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37) ^ (i >> 7) ^ 8'h5A);
   endfunction

   always @(posedge clk_in) begin
      if (!filled) begin
         for (int i = 0; i < 65536; i++) ram[i] = init_byte(i);
         filled = 1'b1;
      end
      if (pre_en) ram[pre_addr] = pre_data;
      if (rdy_in && mem_wr) begin
         if (mem_a[17:16] == 2'b11) io_log.push_back({mem_a, mem_dout});
         else begin
            ram[mem_a[15:0]] = mem_dout;
            wr_log.push_back({mem_a, mem_dout});
         end
      end
   end
   assign mem_din = ram[mem_a[15:0]];

   // Little-endian value of n bytes at a, with 32-bit address wrap.
   function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
      logic [31:0] v;
      logic [31:0] ak;
      v = '0;
      for (int k = 0; k < n; k++) begin
         ak = a + 32'(k);
         v  = v | (32'(model[ak[15:0]]) << (8 * k));
      end
      return v;
   endfunction

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      pre_en   = 1'b0;
      model[a] = d;
   endtask

   // Drives one request from a negedge and waits (bounded) for its done pulse.
   task automatic run_txn(input bit is_ls, input bit wr, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output int edges);
      bit waiting;
      a_trace.delete();
      w_trace.delete();
      rdata = '0;
      edges = 0;
      waiting = 1'b1;
      if (is_ls) begin
         ls_wr = wr; ls_len = len; ls_addr = addr; ls_wdata = wd; ls_req = 1'b1;
      end else begin
         ic_addr = addr; ic_req = 1'b1;
      end
      for (int i = 0; i < 40 && waiting; i++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         edges++;
         a_trace.push_back(mem_a);
         w_trace.push_back(mem_wr);
         if (is_ls ? ls_done : ic_done) begin
            rdata = is_ls ? ls_rdata : ic_data;
            waiting = 1'b0;
         end
      end
      ls_req = 1'b0;
      ic_req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_in);
      checks++;
      if ({mem_a, mem_dout, mem_wr, ic_done, ls_done, ic_data, ls_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got a=%h d=%h wr=%b icd=%b lsd=%b icdata=%h lsdata=%h want all 0",
                  mem_a, mem_dout, mem_wr, ic_done, ls_done, ic_data, ls_rdata);
      end
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);
      checks++;
      if ({mem_a, mem_wr, ic_done, ls_done} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset got a=%h wr=%b icd=%b lsd=%b want 0", mem_a, mem_wr, ic_done, ls_done);
      end
   endtask

   task automatic test_ic_word();
      logic [31:0] rd;
      int edges;
      logic [31:0] exp_a [5];
      int bad;
      poke(16'h0100, 8'h13);
      poke(16'h0101, 8'h05);
      poke(16'h0102, 8'h00);
      poke(16'h0103, 8'h00);
      run_txn(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, rd, edges);
      checks++;
      if (edges !== 6) begin
         errors++; $display("FAIL ic_word_latency got %0d edges want 6", edges);
      end
      checks++;
      if (rd !== 32'h0000_0513) begin
         errors++; $display("FAIL ic_word_data got %h want 00000513", rd);
      end
      exp_a = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h0};
      bad = 0;
      if (a_trace.size() < 5) bad = 1;
      else for (int k = 0; k < 5; k++) if (a_trace[k] !== exp_a[k]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL ic_word_addr_seq got %0d wrong of 5 (first %h) want 100..103,0", bad, a_trace[0]);
      end
      @(posedge clk_in);
      @(negedge clk_in);
      checks++;
      if (ic_done !== 1'b0) begin
         errors++; $display("FAIL ic_done_pulse got %b want 0 one cycle later", ic_done);
      end
   endtask

   task automatic test_priority();
      int ls_edge, ic_edge;
      logic [31:0] ls_val, ic_val, exp_ic;
      poke(16'h0200, 8'hFF);
      exp_ic  = exp_read(32'h300, 4);
      ls_edge = -1; ic_edge = -1; ls_val = '0; ic_val = '0;
      ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'h200; ic_addr = 32'h300;
      ls_req = 1'b1; ic_req = 1'b1;
      for (int e = 1; e <= 30 && ic_edge < 0; e++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (ls_done && ls_edge < 0) begin ls_edge = e; ls_val = ls_rdata; ls_req = 1'b0; end
         if (ic_done && ic_edge < 0) begin ic_edge = e; ic_val = ic_data; ic_req = 1'b0; end
      end
      ls_req = 1'b0; ic_req = 1'b0;
      checks++;
      if (ls_edge !== 3) begin errors++; $display("FAIL prio_ls_latency got %0d want 3", ls_edge); end
      checks++;
      if (ls_val !== 32'h0000_00FF) begin errors++; $display("FAIL prio_ls_data got %h want 000000ff", ls_val); end
      checks++;
      if (ic_edge !== 9) begin errors++; $display("FAIL prio_ic_latency got %0d want 9", ic_edge); end
      checks++;
      if (ic_val !== exp_ic) begin errors++; $display("FAIL prio_ic_data got %h want %h", ic_val, exp_ic); end
   endtask

   task automatic test_store_half();
      logic [31:0] rd;
      int edges, wb;
      logic [7:0] keep;
      keep = model[16'h0402];
      wb = wr_log.size();
      run_txn(1'b1, 1'b1, 2'd1, 32'h400, 32'h1234_ABCD, rd, edges);
      checks++;
      if (edges !== 3) begin errors++; $display("FAIL st_half_latency got %0d want 3", edges); end
      checks++;
      if (wr_log.size() - wb != 2 || wr_log[wb] !== {32'h400, 8'hCD} || wr_log[wb+1] !== {32'h401, 8'hAB}) begin
         errors++;
         $display("FAIL st_half_writes got %0d writes first %h want (400,cd),(401,ab)", wr_log.size() - wb, wr_log[wb]);
      end
      checks++;
      if (w_trace.size() < 3 || {w_trace[0], w_trace[1], w_trace[2]} !== 3'b110) begin
         errors++; $display("FAIL st_half_wr_seq got %b%b%b want 110", w_trace[0], w_trace[1], w_trace[2]);
      end
      model[16'h0400] = 8'hCD;
      model[16'h0401] = 8'hAB;
      run_txn(1'b1, 1'b0, 2'd0, 32'h402, 32'h0, rd, edges);
      checks++;
      if (rd !== {24'h0, keep}) begin errors++; $display("FAIL st_half_neighbour got %h want %h", rd, {24'h0, keep}); end
   endtask

   task automatic test_io_stall();
      int done_e, ib;
      logic [3:0] pat;
      ib = io_log.size();
      done_e = -1; pat = '0;
      io_buffer_full = 1'b1;
      ls_wr = 1'b1; ls_len = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h41; ls_req = 1'b1;
      for (int e = 1; e <= 20 && done_e < 0; e++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (e <= 4) pat[e-1] = mem_wr;
         if (e == 3) io_buffer_full = 1'b0;
         if (ls_done) begin done_e = e; ls_req = 1'b0; end
      end
      ls_req = 1'b0; io_buffer_full = 1'b0;
      checks++;
      if (pat !== 4'b1000) begin errors++; $display("FAIL io_stall_wr_seq got %b want 1000 (edge4..1)", pat); end
      checks++;
      if (done_e !== 5) begin errors++; $display("FAIL io_stall_latency got %0d want 5", done_e); end
      checks++;
      if (io_log.size() - ib != 1 || io_log[ib] !== {32'h0003_0000, 8'h41}) begin
         errors++; $display("FAIL io_stall_write got %0d writes first %h want one (30000,41)", io_log.size() - ib, io_log[ib]);
      end
   endtask

   task automatic test_clear();
      logic [31:0] rd;
      int edges, bad;
      ic_addr = 32'h500; ic_req = 1'b1;
      repeat (2) begin @(posedge clk_in); @(negedge clk_in); end
      clear_in = 1'b1; ic_req = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      clear_in = 1'b0;
      checks++;
      if (mem_a !== 32'h0) begin errors++; $display("FAIL clear_mem_a got %h want 0", mem_a); end
      bad = 0;
      repeat (8) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (ic_done || ls_done || mem_a != 32'h0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL clear_no_done got %0d busy cycles want 0", bad); end
      run_txn(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, rd, edges);
      checks++;
      if (edges !== 6 || rd !== exp_read(32'h0, 4)) begin
         errors++; $display("FAIL clear_follow_read got %0d edges data %h want 6 edges data %h", edges, rd, exp_read(32'h0, 4));
      end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd;
      int edges, wb;
      wb = wr_log.size();
      ls_wr = 1'b1; ls_len = 2'd2; ls_addr = 32'h800; ls_wdata = 32'hC0FF_EE11; ls_req = 1'b1;
      repeat (2) begin @(posedge clk_in); @(negedge clk_in); end
      checks++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h801) begin
         errors++; $display("FAIL pre_reset_write got wr=%b a=%h want 1 801", mem_wr, mem_a);
      end
      rst_in = 1'b0;
      #1;
      checks++;
      if ({mem_a, mem_dout, mem_wr, ic_done, ls_done, ic_data, ls_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_async got a=%h d=%h wr=%b icdata=%h lsdata=%h want all 0",
                  mem_a, mem_dout, mem_wr, ic_data, ls_rdata);
      end
      ls_req = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      checks++;
      if (wr_log.size() - wb != 1) begin
         errors++; $display("FAIL reset_abort_writes got %0d writes want 1", wr_log.size() - wb);
      end
      model[16'h0800] = 8'h11;
      run_txn(1'b1, 1'b0, 2'd2, 32'h800, 32'h0, rd, edges);
      checks++;
      if (edges !== 6 || rd !== exp_read(32'h800, 4)) begin
         errors++; $display("FAIL reset_follow_read got %0d edges data %h want 6 edges data %h", edges, rd, exp_read(32'h800, 4));
      end
   endtask

   task automatic test_rdy_stall();
      int done_e, bad;
      logic [31:0] held, val;
      done_e = -1; bad = 0; held = '0; val = '0;
      ic_addr = 32'h600; ic_req = 1'b1;
      for (int e = 1; e <= 30 && done_e < 0; e++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (e == 2) begin
            rdy_in = 1'b0; held = mem_a;
         end else if (e > 2 && e <= 6) begin
            if (mem_a !== held) bad++;
            if (e == 6) rdy_in = 1'b1;
         end
         if (ic_done) begin done_e = e; val = ic_data; ic_req = 1'b0; end
      end
      ic_req = 1'b0; rdy_in = 1'b1;
      checks++;
      if (held !== 32'h601 || bad != 0) begin
         errors++; $display("FAIL rdy_freeze got a=%h moved %0d times want 601 held", held, bad);
      end
      checks++;
      if (done_e !== 10) begin errors++; $display("FAIL rdy_latency got %0d want 10", done_e); end
      checks++;
      if (val !== exp_read(32'h600, 4)) begin errors++; $display("FAIL rdy_data got %h want %h", val, exp_read(32'h600, 4)); end
   endtask

   task automatic test_random();
      logic [31:0] a, wd, rd, ak;
      logic [1:0] len;
      bit is_ls, wr;
      int n, edges, exp_edges, wb, bad;
      for (int t = 0; t < 41; t++) begin
         if (t == 0) begin
            is_ls = 1'b1; wr = 1'b0; len = 2'd2; a = 32'hFFFF_FFFE;
         end else begin
            is_ls = ($urandom_range(0, 3) != 0);
            wr    = is_ls && ($urandom_range(0, 1) == 1);
            len   = is_ls ? 2'($urandom_range(0, 2)) : 2'd2;
            a     = 32'h1000 + 32'($urandom_range(0, 4095));
         end
         wd = $urandom;
         n  = 1 << len;
         wb = wr_log.size();
         run_txn(is_ls, wr, len, a, wd, rd, edges);
         exp_edges = wr ? n + 1 : n + 2;
         checks++;
         if (edges !== exp_edges) begin
            errors++; $display("FAIL rnd_latency t=%0d got %0d want %0d", t, edges, exp_edges);
         end
         bad = 0;
         if (wr) begin
            if (wr_log.size() - wb != n) bad = 1;
            else for (int k = 0; k < n; k++)
               if (wr_log[wb+k] !== {a + 32'(k), 8'(wd >> (8 * k))}) bad++;
            checks++;
            if (bad != 0) begin
               errors++; $display("FAIL rnd_writes t=%0d got %0d bad of %0d writes at %h want %h", t, bad, n, a, wd);
            end
            for (int k = 0; k < n; k++) begin
               ak = a + 32'(k);
               model[ak[15:0]] = 8'(wd >> (8 * k));
            end
         end else begin
            checks++;
            if (rd !== exp_read(a, n)) begin
               errors++; $display("FAIL rnd_read t=%0d addr %h got %h want %h", t, a, rd, exp_read(a, n));
            end
            if (a_trace.size() < n + 1) bad = 1;
            else begin
               for (int k = 0; k < n; k++) if (a_trace[k] !== a + 32'(k)) bad++;
               if (a_trace[n] !== 32'h0) bad++;
            end
            checks++;
            if (bad != 0) begin
               errors++; $display("FAIL rnd_addr_seq t=%0d addr %h got %0d bad want %h..+%0d then 0", t, a, bad, a, n - 1);
            end
         end
         repeat ($urandom_range(0, 2)) @(negedge clk_in);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0;
      rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
      ic_req = 1'b0; ic_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_len = '0;
      ls_addr = '0; ls_wdata = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      for (int i = 0; i < 65536; i++) model[i] = init_byte(i);
      test_reset();
      test_ic_word();
      test_priority();
      test_store_half();
      test_io_stall();
      test_clear();
      test_reset_mid_write();
      test_rdy_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
